rdma_xmit: RTL and testbench

RDMA_XMIT -- requirements
Module: rdma_xmit

---
 rtl/rdma_pkg.sv | 18 +
 rtl/rdma_ip4_csum.sv | 24 ++
 rtl/rdma_xmit.sv | 97 +++++++++
 tb/tb_rdma_xmit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_pkg.sv
// rdma_pkg: shared constants, FSM state type and length helpers for the RDMA transmitter
package rdma_pkg;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam int IP_HDR_LEN = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int RDMA_HDR_LEN = 22;
  localparam int HDR_BYTES = 64;
  localparam logic [15:0] IP_VER_TOS = 16'h4500;
  localparam logic [15:0] IP_ID = 16'h0000;
  localparam logic [15:0] IP_FLAGS = 16'h4000;
  localparam logic [15:0] IP_TTL_PROTO = 16'h4011;
  localparam logic [15:0] UDP_CSUM = 16'h0000;
  typedef enum logic [2:0] {IDLE, CSUM, HDR, DATA, RESP} state_t;
  // payload bytes of a burst: (len+1) beats of 64 bytes, at most 16384
  function automatic logic [15:0] payload_len(input logic [7:0] len);
    return ({8'd0, len} + 16'd1) << 6;
  endfunction
endpackage

// File: rtl/rdma_ip4_csum.sv
// rdma_ip4_csum: registered IPv4 header checksum over ten 16-bit words.
// Computed only with RDMA_XMIT_IPCSUM_EN defined; otherwise the result is a constant 0.
module rdma_ip4_csum (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0][15:0] words,
  output logic [15:0]     csum
);
`ifdef RDMA_XMIT_IPCSUM_EN
  logic [19:0] sum;
  logic [16:0] fold;
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + 20'(words[i]);
    fold = 17'(sum[15:0]) + 17'(sum[19:16]);
  end
  // a second end-around carry cannot overflow: fold[16] set implies fold[15:0] is tiny
  always_ff @(posedge clk) csum <= reset ? 16'h0 : ~(fold[15:0] + 16'(fold[16]));
`else
  logic unused_words;
  assign unused_words = ^{words, reset};
  always_ff @(posedge clk) csum <= 16'h0;
`endif
endmodule

// File: rtl/rdma_xmit.sv
// rdma_xmit: turns each AXI write burst into one RDMA-over-UDP/IPv4 packet (64-byte header + AWLEN+1 data beats).
// Define RDMA_XMIT_IPCSUM_EN to fill in the IPv4 header checksum; otherwise it is sent as zero.
module rdma_xmit
  import rdma_pkg::*;
#(
  parameter int DATA_WBITS = 512,
  parameter int ADDR_WBITS = 64,
  localparam int DATA_WBYTS = DATA_WBITS / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WBITS-1:0] S_AXI_AWADDR,
  input  logic [7:0]            S_AXI_AWLEN,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_WBITS-1:0] S_AXI_WDATA,
  input  logic [DATA_WBYTS-1:0] S_AXI_WSTRB,
  input  logic                  S_AXI_WLAST,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [DATA_WBITS-1:0] AXIS_RDMA_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_RDMA_TKEEP,
  output logic                  AXIS_RDMA_TVALID,
  output logic                  AXIS_RDMA_TLAST,
  input  logic                  AXIS_RDMA_TREADY,
  input  logic [47:0]           SRC_MAC,
  input  logic [47:0]           DST_MAC,
  input  logic [31:0]           SRC_IP,
  input  logic [31:0]           DST_IP,
  input  logic [15:0]           SRC_PORT,
  input  logic [15:0]           DST_PORT
);
  state_t state;
  logic [ADDR_WBITS-1:0] addr;
  logic [7:0] len, beat;
  logic err, last, w_fire;
  logic [15:0] ip_len, udp_len, csum;
  logic [8*HDR_BYTES-1:0] hdr_be, hdr;
  assign ip_len = payload_len(len) + 16'(IP_HDR_LEN + UDP_HDR_LEN + RDMA_HDR_LEN);
  assign udp_len = payload_len(len) + 16'(UDP_HDR_LEN + RDMA_HDR_LEN);
  rdma_ip4_csum u_csum (
    .clk(clk),
    .reset(reset),
    .words({IP_VER_TOS, ip_len, IP_ID, IP_FLAGS, IP_TTL_PROTO, 16'h0000, SRC_IP, DST_IP}),
    .csum(csum)
  );
  // wire order: first field at the MSB end, then byte-swapped so wire byte 0 lands in TDATA[7:0]
  assign hdr_be = {DST_MAC, SRC_MAC, ETH_TYPE_IPV4, IP_VER_TOS, ip_len, IP_ID, IP_FLAGS,
                   IP_TTL_PROTO, csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len, UDP_CSUM,
                   64'(addr), len, 104'd0};
  for (genvar i = 0; i < HDR_BYTES; i++) begin : g_swap
    assign hdr[8*i +: 8] = hdr_be[8*HDR_BYTES-1-8*i -: 8];
  end
  assign last = beat == len;
  assign w_fire = S_AXI_WVALID && AXIS_RDMA_TREADY;
  assign S_AXI_AWREADY = state == IDLE && !reset;
  assign S_AXI_WREADY = state == DATA && AXIS_RDMA_TREADY;
  assign S_AXI_BVALID = state == RESP;
  assign S_AXI_BRESP = (state == RESP && err) ? 2'b10 : 2'b00;
  assign AXIS_RDMA_TVALID = state == HDR || (state == DATA && S_AXI_WVALID);
  assign AXIS_RDMA_TDATA = state == DATA ? S_AXI_WDATA : DATA_WBITS'(hdr);
  assign AXIS_RDMA_TKEEP = state == DATA ? S_AXI_WSTRB : '1;
  assign AXIS_RDMA_TLAST = state == DATA && last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      beat <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (S_AXI_AWVALID) begin
          addr <= S_AXI_AWADDR;
          len <= S_AXI_AWLEN;
          beat <= '0;
          state <= CSUM;
        end
        CSUM: state <= HDR;
        HDR: if (AXIS_RDMA_TREADY) state <= DATA;
        DATA: if (w_fire) begin
          beat <= beat + 8'd1;
          err <= err | (S_AXI_WLAST != last);
          if (last) state <= RESP;
        end
        RESP: if (S_AXI_BREADY) begin
          state <= IDLE;
          err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rdma_xmit.sv
// tb_rdma_xmit: randomized AXI bursts checked against a byte-level packet model of rdma_xmit
module tb_rdma_xmit;
  localparam int DW = 512;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] S_AXI_AWADDR;
  logic [7:0] S_AXI_AWLEN;
  logic S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [63:0] S_AXI_WSTRB;
  logic S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0] S_AXI_BRESP;
  logic S_AXI_BVALID, S_AXI_BREADY;
  logic [DW-1:0] AXIS_RDMA_TDATA;
  logic [63:0] AXIS_RDMA_TKEEP;
  logic AXIS_RDMA_TVALID, AXIS_RDMA_TLAST, AXIS_RDMA_TREADY;
  logic [47:0] SRC_MAC, DST_MAC;
  logic [31:0] SRC_IP, DST_IP;
  logic [15:0] SRC_PORT, DST_PORT;
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] last_hdr;
  int last_beats;

  always #5 clk = ~clk;

  rdma_xmit dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .AXIS_RDMA_TDATA(AXIS_RDMA_TDATA), .AXIS_RDMA_TKEEP(AXIS_RDMA_TKEEP),
    .AXIS_RDMA_TVALID(AXIS_RDMA_TVALID), .AXIS_RDMA_TLAST(AXIS_RDMA_TLAST),
    .AXIS_RDMA_TREADY(AXIS_RDMA_TREADY),
    .SRC_MAC(SRC_MAC), .DST_MAC(DST_MAC), .SRC_IP(SRC_IP), .DST_IP(DST_IP),
    .SRC_PORT(SRC_PORT), .DST_PORT(DST_PORT)
  );

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input int ip);
`ifdef RDMA_XMIT_IPCSUM_EN
    int w[10];
    longint s;
    w = '{32'h4500, ip, 0, 32'h4000, 32'h4011, 0, int'(SRC_IP[31:16]), int'(SRC_IP[15:0]),
          int'(DST_IP[31:16]), int'(DST_IP[15:0])};
    s = 0;
    foreach (w[i]) s += longint'(w[i]);
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    return ~s[15:0];
`else
    return ip == -1 ? 16'h1 : 16'h0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_hdr(input logic [63:0] a, input int len);
    logic [7:0] b[64];
    int w[19];
    int ip;
    logic [DW-1:0] r;
    ip = 50 + (len + 1) * 64;
    w = '{32'h0800, 32'h4500, ip, 0, 32'h4000, 32'h4011, int'(model_csum(ip)),
          int'(SRC_IP[31:16]), int'(SRC_IP[15:0]), int'(DST_IP[31:16]), int'(DST_IP[15:0]),
          int'(SRC_PORT), int'(DST_PORT), ip - 20, 0,
          int'(a[63:48]), int'(a[47:32]), int'(a[31:16]), int'(a[15:0])};
    foreach (b[i]) b[i] = 8'h0;
    for (int i = 0; i < 6; i++) begin
      b[i] = DST_MAC[47-8*i -: 8];
      b[6+i] = SRC_MAC[47-8*i -: 8];
    end
    for (int k = 0; k < 19; k++) begin
      b[12+2*k] = 8'(w[k] >> 8);
      b[13+2*k] = 8'(w[k]);
    end
    b[50] = 8'(len);
    for (int i = 0; i < 64; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [15:0] hdr16(input int off);
    logic [7:0] hi, lo;
    hi = last_hdr[8*off +: 8];
    lo = last_hdr[8*(off+1) +: 8];
    return {hi, lo};
  endfunction

  task automatic rst_outputs(input string tag);
    chk({tag, "_awready"}, S_AXI_AWREADY, 0);
    chk({tag, "_wready"}, S_AXI_WREADY, 0);
    chk({tag, "_bvalid"}, S_AXI_BVALID, 0);
    chk({tag, "_bresp"}, S_AXI_BRESP, 0);
    chk({tag, "_tvalid"}, AXIS_RDMA_TVALID, 0);
    chk({tag, "_tlast"}, AXIS_RDMA_TLAST, 0);
  endtask

  // bad: beat index carrying WLAST (-1 = correct), mode: 0 full rate, 1 TREADY toggling, 2 random
  // abort: number of delivered beats after which reset is asserted (-1 = none)
  task automatic burst(input logic [63:0] a, input int len, input int bad, input int mode, input int abort);
    logic [DW-1:0] d[$];
    logic [63:0] s[$];
    logic [DW+63:0] rb[$];
    logic rl[$];
    logic [DW+63:0] held;
    logic [DW-1:0] t;
    logic hv, wf;
    int wi, cyc;
    for (int i = 0; i <= len; i++) begin
      for (int j = 0; j < DW / 32; j++) t[32*j +: 32] = $urandom();
      d.push_back(t);
      s.push_back({$urandom(), $urandom()});
    end
    @(negedge clk);
    S_AXI_AWADDR = a;
    S_AXI_AWLEN = 8'(len);
    S_AXI_AWVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_AWREADY && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("aw_ready", S_AXI_AWREADY, 1);
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    chk("csum_cycle_tvalid", AXIS_RDMA_TVALID, 0);
    chk("aw_busy", S_AXI_AWREADY, 0);
    wi = 0;
    hv = 1'b0;
    wf = 1'b0;
    cyc = 0;
    while (rb.size() < len + 2 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (abort >= 0 && rb.size() == abort) break;
      if (wf) begin
        wi++;
        S_AXI_WVALID = 1'b0;
      end
      AXIS_RDMA_TREADY = (mode == 0) || (mode == 1 && cyc % 2 == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      if (!S_AXI_WVALID && wi <= len) S_AXI_WVALID = mode != 2 || $urandom_range(0, 3) != 0;
      if (wi <= len) begin
        S_AXI_WDATA = d[wi];
        S_AXI_WSTRB = s[wi];
        S_AXI_WLAST = bad >= 0 ? wi == bad : wi == len;
      end
      #1;
      if (cyc == 1) chk("hdr_latency", AXIS_RDMA_TVALID, 1);
      if (hv) chk("stall_hold", {AXIS_RDMA_TVALID, AXIS_RDMA_TKEEP, AXIS_RDMA_TDATA}, {1'b1, held});
      hv = AXIS_RDMA_TVALID && !AXIS_RDMA_TREADY;
      held = {AXIS_RDMA_TKEEP, AXIS_RDMA_TDATA};
      if (AXIS_RDMA_TVALID && AXIS_RDMA_TREADY) begin
        rb.push_back(held);
        rl.push_back(AXIS_RDMA_TLAST);
      end
      wf = S_AXI_WVALID && S_AXI_WREADY;
    end
    if (abort >= 0) begin
      reset = 1'b1;
      @(negedge clk);
      S_AXI_WVALID = 1'b0;
      rst_outputs("mid_rst");
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_release_aw", S_AXI_AWREADY, 1);
      return;
    end
    chk("beat_count", rb.size(), len + 2);
    @(negedge clk);
    S_AXI_WVALID = 1'b0;
    chk("bvalid", S_AXI_BVALID, 1);
    chk("aw_blocked_in_resp", S_AXI_AWREADY, 0);
    chk("bresp", S_AXI_BRESP, (bad >= 0 && bad != len) ? 2 : 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("bvalid_hold", S_AXI_BVALID, 1);
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", S_AXI_BVALID, 0);
    last_beats = rb.size();
    if (rb.size() > 0) begin
      last_hdr = rb[0][DW-1:0];
      chk("hdr", rb[0], {{64{1'b1}}, model_hdr(a, len)});
      chk("hdr_tlast", rl[0], 0);
    end
    for (int i = 0; i < rb.size() - 1 && i <= len; i++) begin
      chk("data", rb[i+1], {s[i], d[i]});
      chk("data_tlast", rl[i+1], i == len);
    end
  endtask

  task automatic new_fields();
    SRC_MAC = {$urandom(), 16'($urandom())};
    DST_MAC = {$urandom(), 16'($urandom())};
    SRC_IP = $urandom();
    DST_IP = $urandom();
    SRC_PORT = 16'($urandom());
    DST_PORT = 16'($urandom());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr_f;
    int len, bad;
    reset = 1'b1;
    S_AXI_AWADDR = '0;
    S_AXI_AWLEN = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0;
    S_AXI_WSTRB = '0;
    S_AXI_WLAST = 1'b0;
    S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    AXIS_RDMA_TREADY = 1'b0;
    new_fields();
    repeat (3) @(negedge clk);
    rst_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("aw_after_reset", S_AXI_AWREADY, 1);
    burst(64'h0000_0001_2345_6780, 3, -1, 0, -1);
    chk("udp_len_len3", hdr16(38), 16'h011E);
    chk("ip_len_len3", hdr16(16), 16'h0132);
    chk("burst_len_len3", last_hdr[8*50 +: 8], 8'h03);
    for (int i = 0; i < 8; i++) addr_f[63-8*i -: 8] = last_hdr[8*(42+i) +: 8];
    chk("addr_field", addr_f, 64'h0000_0001_2345_6780);
    chk("beats_len3", last_beats, 5);
    burst({$urandom(), $urandom()}, 0, -1, 0, -1);
    chk("beats_len0", last_beats, 2);
    burst({$urandom(), $urandom()}, 255, -1, 0, -1);
    chk("ip_len_len255", hdr16(16), 16'h4032);
    chk("beats_len255", last_beats, 257);
    burst({$urandom(), $urandom()}, 5, -1, 1, -1);
    burst({$urandom(), $urandom()}, 3, 1, 1, -1);
    chk("beats_early_wlast", last_beats, 5);
    burst({$urandom(), $urandom()}, 2, -1, 0, -1);
    SRC_IP = 32'hC0A80001;
    DST_IP = 32'hC0A800C7;
    burst({$urandom(), $urandom()}, 0, -1, 0, -1);
`ifdef RDMA_XMIT_IPCSUM_EN
    chk("ip_csum", hdr16(24), 16'hB862);
`else
    chk("ip_csum", hdr16(24), 16'h0000);
`endif
    for (int n = 0; n < 8; n++) begin
      new_fields();
      len = $urandom_range(0, 15);
      bad = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, len)) : -1;
      burst({$urandom(), $urandom()}, len, bad, 2, -1);
    end
    burst({$urandom(), $urandom()}, 7, -1, 0, 2);
    burst({$urandom(), $urandom()}, 1, -1, 0, -1);
    chk("beats_after_reset", last_beats, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
